sw_conditioner: RTL

- Upstream front end for the rice-machine LED sequencer.
- Takes the raw, asynchronous mode switch and produces a synchronised, debounced level (sw_clean) with one-cycle edge pulses.
- Also produces a single-cycle step strobe (step_tick) that the sequencer uses as its advance enable, instead of a divided clock.
- The step strobe re-phases on every debounced switch change, so the first sequencer step after a mode change always occurs exactly one full step period later.

---
 rtl/sw_conditioner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sw_conditioner.sv
// Switch front end: synchronise and debounce the mode switch, emit edge pulses and a re-phasable step strobe.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a clean sw_raw step to sw_clean; no backpressure, free-running.
module sw_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic step_tick
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sw_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sw_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (STEP_CYCLES < 2) begin : g_bad_step
    $error("sw_conditioner: STEP_CYCLES must be >= 2");
  end

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI   = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_sync;
  logic [1:0]             state, state_n;
  logic [DW-1:0]          db_cnt, db_cnt_n;
  logic                   clean_n, rise_n, fall_n, commit;
  logic [SW-1:0]          step_cnt;

  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign commit  = rise_n | fall_n;

  always_comb begin
    state_n  = state;
    db_cnt_n = db_cnt;
    clean_n  = sw_clean;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sw_sync) begin
          // A single-cycle debounce window accepts the new level immediately.
          if (DEBOUNCE_CYCLES == 1) begin
            state_n  = STABLE_HI;
            db_cnt_n = '0;
            clean_n  = 1'b1;
            rise_n   = 1'b1;
          end else begin
            state_n  = WAIT_HI;
            db_cnt_n = DW'(1);
          end
        end
      end
      WAIT_HI: begin
        if (!sw_sync) begin
          state_n  = STABLE_LO;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n  = STABLE_HI;
          db_cnt_n = '0;
          clean_n  = 1'b1;
          rise_n   = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DW'(1);
        end
      end
      STABLE_HI: begin
        if (!sw_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n  = STABLE_LO;
            db_cnt_n = '0;
            clean_n  = 1'b0;
            fall_n   = 1'b1;
          end else begin
            state_n  = WAIT_LO;
            db_cnt_n = DW'(1);
          end
        end
      end
      WAIT_LO: begin
        if (sw_sync) begin
          state_n  = STABLE_HI;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n  = STABLE_LO;
          db_cnt_n = '0;
          clean_n  = 1'b0;
          fall_n   = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DW'(1);
        end
      end
      default: begin
        state_n  = STABLE_LO;
        db_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      state     <= STABLE_LO;
      db_cnt    <= '0;
      sw_clean  <= 1'b0;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
      step_cnt  <= '0;
      step_tick <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      state    <= state_n;
      db_cnt   <= db_cnt_n;
      sw_clean <= clean_n;
      sw_rise  <= rise_n;
      sw_fall  <= fall_n;
      // A committed switch change restarts the step period and swallows a coincident wrap.
      if (commit) begin
        step_cnt  <= '0;
        step_tick <= 1'b0;
      end else if (step_cnt == STEP_LAST) begin
        step_cnt  <= '0;
        step_tick <= 1'b1;
      end else begin
        step_cnt  <= step_cnt + SW'(1);
        step_tick <= 1'b0;
      end
    end
  end

endmodule
